// File: rtl/hline_zbuff_pkg.sv
// Shared definitions for the hline z-buffer setup path: default widths, state encoding, divider pacing.
// HLINE_SETUP_RADIX4_EN selects a divider that retires two quotient bits per cycle.
package hline_zbuff_pkg;

  localparam int Z_W_DEF    = 32;
  localparam int X_W_DEF    = 16;
  localparam int ADDR_W_DEF = 32;

`ifdef HLINE_SETUP_RADIX4_EN
  localparam int STEPS_PER_CYCLE = 2;
`else
  localparam int STEPS_PER_CYCLE = 1;
`endif

  localparam int DIV_CYCLES = Z_W_DEF / STEPS_PER_CYCLE;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SORT,
    ST_DIV,
    ST_ISSUE
  } state_t;

endpackage

// File: rtl/hline_div.sv
// Iterative restoring unsigned divider; one or two quotient bits per cycle (HLINE_SETUP_RADIX4_EN).
// quotient/remainder hold their last value until the next load or clear.
module hline_div
  import hline_zbuff_pkg::*;
#(
  parameter int W = Z_W_DEF
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CYCLES = W / STEPS_PER_CYCLE;
  localparam int CNT_W  = $clog2(CYCLES + 1);

  logic [W-1:0]     d_reg;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     q_next;
  logic [W-1:0]     r_next;
  logic [W:0]       trial;

  assign busy = (cnt != '0);
  assign done = (cnt == CNT_W'(1));

  // quotient register doubles as the dividend shift register
  always_comb begin
    q_next = quotient;
    r_next = remainder;
    trial  = '0;
    for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
      trial  = {r_next, q_next[W-1]};
      q_next = {q_next[W-2:0], 1'b0};
      if (trial >= {1'b0, d_reg}) begin
        trial     = trial - {1'b0, d_reg};
        q_next[0] = 1'b1;
      end
      r_next = trial[W-1:0];
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      quotient  <= '0;
      remainder <= '0;
      d_reg     <= '0;
      cnt       <= '0;
    end else if (clear) begin
      quotient  <= '0;
      remainder <= '0;
      cnt       <= '0;
    end else if (load) begin
      quotient  <= dividend;
      remainder <= '0;
      d_reg     <= divisor;
      cnt       <= CNT_W'(CYCLES);
    end else if (busy) begin
      quotient  <= q_next;
      remainder <= r_next;
      cnt       <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/hline_zsetup.sv
// Span setup ahead of the hline z-buffer FSM: orders endpoints, divides |dz| by dx, holds start until line_done.
// HLINE_SETUP_RADIX4_EN halves the divide phase (see hline_zbuff_pkg).
module hline_zsetup
  import hline_zbuff_pkg::*;
#(
  parameter int Z_W    = Z_W_DEF,
  parameter int X_W    = X_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [X_W-1:0]    cmd_x1,
  input  logic [X_W-1:0]    cmd_x2,
  input  logic [Z_W-1:0]    cmd_z1,
  input  logic [Z_W-1:0]    cmd_z2,
  input  logic [ADDR_W-1:0] cmd_y,
  input  logic [ADDR_W-1:0] cmd_fb_addr,
  input  logic [ADDR_W-1:0] cmd_zbuff_addr,
  input  logic              line_done,
  output logic              start,
  output logic [X_W-1:0]    x1,
  output logic [X_W-1:0]    x2,
  output logic [Z_W-1:0]    z1,
  output logic [Z_W-1:0]    z2,
  output logic              z_neg,
  output logic [Z_W-1:0]    slope,
  output logic [Z_W-1:0]    rem,
  output logic [Z_W-1:0]    err,
  output logic [ADDR_W-1:0] y,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [ADDR_W-1:0] zbuff_addr
);

  state_t state, state_n;

  logic           swap;
  logic [X_W-1:0] xa, xb, dx;
  logic [Z_W-1:0] za, zb, dz;
  logic [X_W:0]   dx_p1;
  logic           in_sort, div_load, div_clear, div_busy, div_done;

  // x1/x2/z1/z2 hold the raw command during SORT and are rewritten in order at its end
  always_comb begin
    swap    = (x1 > x2);
    xa      = swap ? x2 : x1;
    xb      = swap ? x1 : x2;
    za      = swap ? z2 : z1;
    zb      = swap ? z1 : z2;
    dx      = xb - xa;
    dz      = (zb < za) ? (za - zb) : (zb - za);
    dx_p1   = {1'b0, dx} + {{X_W{1'b0}}, 1'b1};
    in_sort = (state == ST_SORT);
    div_load  = in_sort && (dx != '0);
    div_clear = in_sort && (dx == '0);
  end

  assign cmd_ready = (state == ST_IDLE);
  assign start     = (state == ST_ISSUE);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) state <= ST_IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:  if (cmd_valid) state_n = ST_SORT;
      ST_SORT:  state_n = (dx == '0) ? ST_ISSUE : ST_DIV;
      ST_DIV:   if (div_done || !div_busy) state_n = ST_ISSUE;
      ST_ISSUE: if (line_done) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      x1         <= '0;
      x2         <= '0;
      z1         <= '0;
      z2         <= '0;
      z_neg      <= 1'b0;
      err        <= '0;
      y          <= '0;
      fb_addr    <= '0;
      zbuff_addr <= '0;
    end else if (state == ST_IDLE && cmd_valid) begin
      x1         <= cmd_x1;
      x2         <= cmd_x2;
      z1         <= cmd_z1;
      z2         <= cmd_z2;
      y          <= cmd_y;
      fb_addr    <= cmd_fb_addr;
      zbuff_addr <= cmd_zbuff_addr;
    end else if (in_sort) begin
      x1    <= xa;
      x2    <= xb;
      z1    <= za;
      z2    <= zb;
      z_neg <= (zb < za);
      err   <= Z_W'(dx_p1 >> 1);
    end
  end

  // a zero-width span clears the divider so slope/rem read as 0 without dividing
  hline_div #(
    .W(Z_W)
  ) u_div (
    .clk       (clk),
    .nreset    (nreset),
    .load      (div_load),
    .clear     (div_clear),
    .dividend  (dz),
    .divisor   (Z_W'(dx)),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (slope),
    .remainder (rem)
  );

endmodule
